// File: rtl/kronos_types.sv
// Shared types for the Kronos memory arbiter: requester identity and the
// arbiter FSM state encoding.
package kronos_types;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    // Locked state that corresponds to a given owner.
    function automatic arb_state_t owner_state(arb_owner_t o);
        return (o == ARB_INSTR) ? ST_INSTR : ST_DATA;
    endfunction

endpackage

// File: rtl/kronos_mem_arb.sv
// Kronos memory arbiter: shares one single-port memory between the fetch
// unit and the LSU. Arbitration is combinational (zero-cycle latency); a
// multi-cycle access locks the owner until mem_gnt or until the owner drops
// its request (abort).
// Build option: KRONOS_ARB_RR_EN selects round-robin between simultaneous
// requesters; without it the LSU always wins a tie.
module kronos_mem_arb
    import kronos_types::*;
(
    input  logic        clk,
    input  logic        rstz,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_gnt,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    output logic [31:0] data_rd_data,
    output logic        data_gnt,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt
);

    arb_state_t state, state_nxt;
    arb_owner_t pick;
    arb_owner_t owner;
    logic       data_req;
    logic       active;

`ifdef KRONOS_ARB_RR_EN
    arb_owner_t last_owner;
`endif

    assign data_req = data_rd_req | data_wr_req;

    // Tie-break between requesters, only consulted in IDLE.
    always_comb begin
        pick = ARB_DATA;
        if (instr_req && data_req) begin
`ifdef KRONOS_ARB_RR_EN
            pick = (last_owner == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
`else
            // The load/store belongs to an older instruction and the
            // pipeline is stalled behind it, so it goes first.
            pick = ARB_DATA;
`endif
        end else if (instr_req) begin
            pick = ARB_INSTR;
        end
    end

    // FSM next state, owner selection and memory/grant routing.
    always_comb begin
        state_nxt   = ST_IDLE;
        owner       = pick;
        active      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        instr_gnt   = 1'b0;
        data_gnt    = 1'b0;

        case (state)
            ST_IDLE: begin
                owner  = pick;
                active = instr_req | data_req;
            end
            ST_INSTR: begin
                owner  = ARB_INSTR;
                active = instr_req;
            end
            ST_DATA: begin
                owner  = ARB_DATA;
                active = data_req;
            end
            default: begin
                owner  = pick;
                active = 1'b0;
            end
        endcase

        // Reset drops any in-flight access immediately.
        if (!rstz) active = 1'b0;

        if (active) begin
            if (owner == ARB_INSTR) begin
                mem_addr   = instr_addr;
                mem_rd_req = 1'b1;
                instr_gnt  = mem_gnt;
            end else begin
                mem_addr    = data_addr;
                mem_wr_data = data_wr_data;
                mem_rd_req  = data_rd_req;
                // A read wins if the LSU ever raises both.
                mem_wr_req  = data_wr_req & ~data_rd_req;
                data_gnt    = mem_gnt;
            end
        end

        // Lock while the access is outstanding; completion or abort
        // (owner request gone) both return to IDLE.
        if (active && !mem_gnt) state_nxt = owner_state(owner);
    end

    // Read data is broadcast; the grant says who it is for.
    assign instr_data   = rstz ? mem_rd_data : '0;
    assign data_rd_data = rstz ? mem_rd_data : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= ST_IDLE;
        else       state <= state_nxt;
    end

`ifdef KRONOS_ARB_RR_EN
    // Remember who completed last so ties alternate.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz)                  last_owner <= ARB_INSTR;
        else if (active && mem_gnt) last_owner <= owner;
    end
`endif

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Self-checking bench for kronos_mem_arb: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_kronos_mem_arb;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_data;
    logic        instr_gnt;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic        data_rd_req = 1'b0;
    logic        data_wr_req = 1'b0;
    logic [31:0] data_rd_data;
    logic        data_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_rd_data = '0;
    logic        mem_gnt = 1'b0;

    always #5 clk = ~clk;

    kronos_mem_arb dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_gnt(instr_gnt),
        .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_rd_data(data_rd_data), .data_gnt(data_gnt),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_rd_data(mem_rd_data), .mem_gnt(mem_gnt)
    );

    int checks = 0;
    int failures = 0;

`ifdef KRONOS_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Model: who holds the memory (0 none, 1 fetch, 2 LSU) and who last
    // completed an access.
    int m_hold, m_last, nxt_hold, nxt_last;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_rd, e_wr, e_ig, e_dg;

    task automatic model_reset();
        m_hold = 0; m_last = 1; nxt_hold = 0; nxt_last = 1;
    endtask

    task automatic model_eval();
        int who;
        bit ireq, dreq;
        ireq = instr_req;
        dreq = data_rd_req | data_wr_req;
        who = 0;
        if (rstz) begin
            if (m_hold == 0) begin
                if (ireq && dreq) who = RR_EN ? ((m_last == 1) ? 2 : 1) : 2;
                else if (ireq)    who = 1;
                else if (dreq)    who = 2;
            end else if (m_hold == 1) begin
                who = ireq ? 1 : 0;
            end else begin
                who = dreq ? 2 : 0;
            end
        end
        e_addr  = (who == 1) ? instr_addr : (who == 2) ? data_addr : 32'h0;
        e_wdata = (who == 2) ? data_wr_data : 32'h0;
        e_rd    = (who == 1) || (who == 2 && data_rd_req);
        e_wr    = (who == 2) && data_wr_req;
        e_ig    = (who == 1) && mem_gnt;
        e_dg    = (who == 2) && mem_gnt;
        e_rdata = rstz ? mem_rd_data : 32'h0;
        nxt_hold = (who != 0 && !mem_gnt) ? who : 0;
        nxt_last = (who != 0 && mem_gnt) ? who : m_last;
        if (!rstz) begin
            nxt_hold = 0;
            nxt_last = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_hold = nxt_hold;
        m_last = nxt_last;
    endtask

    task automatic clear_inputs();
        instr_req = 0; data_rd_req = 0; data_wr_req = 0; mem_gnt = 0;
        instr_addr = 0; data_addr = 0; data_wr_data = 0; mem_rd_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstz = 0;
        model_reset();
        #2;
        checks++;
        if ({mem_addr, mem_wr_data, mem_rd_req, mem_wr_req, instr_gnt, data_gnt,
             instr_data, data_rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h rd=%b wr=%b ig=%b dg=%b expected all zero",
                     mem_addr, mem_rd_req, mem_wr_req, instr_gnt, data_gnt);
        end
        #11 rstz = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle_instr();
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 1; mem_rd_data = 32'hDEADBEEF;
        #1; model_eval();
        checks++;
        if (instr_gnt !== 1'b1 || instr_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_instr_gnt: got gnt=%b data=%h expected 1/deadbeef", instr_gnt, instr_data);
        end
        checks++;
        if (mem_addr !== 32'h100 || mem_rd_req !== 1'b1 || data_gnt !== 1'b0) begin
            failures++;
            $display("FAIL single_instr_mem: got addr=%h rd=%b dg=%b expected 100/1/0", mem_addr, mem_rd_req, data_gnt);
        end
        tick();
        // Still IDLE: an LSU-only request is served at once.
        instr_req = 0; data_rd_req = 1; data_addr = 32'h104; mem_rd_data = 32'h0BADF00D;
        #1; model_eval();
        checks++;
        if (data_gnt !== 1'b1 || mem_addr !== 32'h104 || instr_gnt !== 1'b0) begin
            failures++;
            $display("FAIL single_stays_idle: got dg=%b addr=%h ig=%b expected 1/104/0", data_gnt, mem_addr, instr_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        instr_req = 1; instr_addr = 32'h200;
        data_rd_req = 1; data_addr = 32'h300; mem_gnt = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin mem_gnt = 1; mem_rd_data = 32'hCAFE0001; end
            #1; model_eval();
            checks++;
            if (mem_addr !== 32'h300 || data_gnt !== (c == 3) || instr_gnt !== 1'b0) begin
                failures++;
                $display("FAIL prio_cycle%0d: got addr=%h dg=%b ig=%b expected 300/%0d/0", c, mem_addr, data_gnt, instr_gnt, (c == 3));
            end
            tick();
        end
        data_rd_req = 0; mem_gnt = 1; mem_rd_data = 32'h000000A5;
        #1; model_eval();
        checks++;
        if (instr_gnt !== 1'b1 || mem_addr !== 32'h200 || instr_data !== 32'hA5) begin
            failures++;
            $display("FAIL prio_no_bubble: got ig=%b addr=%h data=%h expected 1/200/a5", instr_gnt, mem_addr, instr_data);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        // Fresh reset so the tie history starts at fetch.
        rstz = 0; model_reset(); #2; rstz = 1;
        @(posedge clk); #1;
        instr_req = 1; instr_addr = 32'h10; data_rd_req = 1; data_addr = 32'h20; mem_gnt = 1;
        for (int c = 0; c < 3; c++) begin
            #1; model_eval();
            checks++;
            if (data_gnt !== (c != 1) || instr_gnt !== (c == 1)) begin
                failures++;
                $display("FAIL rr_grant%0d: got dg=%b ig=%b expected %0d/%0d", c, data_gnt, instr_gnt, (c != 1), (c == 1));
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock_instr();
        instr_req = 1; instr_addr = 32'h400; mem_gnt = 0;
        #1; model_eval(); tick();
        data_wr_req = 1; data_addr = 32'h500; data_wr_data = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            #1; model_eval();
            checks++;
            if (mem_wr_req !== 1'b0 || mem_addr !== 32'h400 || data_gnt !== 1'b0 || mem_wr_data !== 32'h0) begin
                failures++;
                $display("FAIL lock_hold%0d: got wr=%b addr=%h dg=%b wd=%h expected 0/400/0/0", c, mem_wr_req, mem_addr, data_gnt, mem_wr_data);
            end
            tick();
        end
        mem_gnt = 1;
        #1; model_eval();
        checks++;
        if (instr_gnt !== 1'b1 || mem_wr_req !== 1'b0 || data_gnt !== 1'b0) begin
            failures++;
            $display("FAIL lock_release: got ig=%b wr=%b dg=%b expected 1/0/0", instr_gnt, mem_wr_req, data_gnt);
        end
        tick();
        instr_req = 0;
        #1; model_eval();
        checks++;
        if (mem_wr_req !== 1'b1 || mem_wr_data !== 32'h12345678 || mem_addr !== 32'h500 || data_gnt !== 1'b1) begin
            failures++;
            $display("FAIL lock_store: got wr=%b wd=%h addr=%h dg=%b expected 1/12345678/500/1", mem_wr_req, mem_wr_data, mem_addr, data_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_abort();
        data_rd_req = 1; data_addr = 32'h600; mem_gnt = 0;
        #1; model_eval(); tick();
        // LSU gives up; fetch is waiting but must not sneak in this cycle.
        data_rd_req = 0; instr_req = 1; instr_addr = 32'h700;
        #1; model_eval();
        checks++;
        if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 || instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle: got rd=%b wr=%b ig=%b dg=%b expected all 0", mem_rd_req, mem_wr_req, instr_gnt, data_gnt);
        end
        tick();
        mem_gnt = 1;
        #1; model_eval();
        checks++;
        if (instr_gnt !== 1'b1 || mem_addr !== 32'h700 || data_gnt !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got ig=%b addr=%h dg=%b expected 1/700/0", instr_gnt, mem_addr, data_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_access();
        data_rd_req = 1; data_addr = 32'h800; mem_gnt = 0;
        #1; model_eval(); tick();
        rstz = 0; mem_gnt = 1; mem_rd_data = 32'h55AA55AA;
        model_reset();
        #1;
        checks++;
        if (mem_rd_req !== 1'b0 || mem_addr !== 32'h0 || data_gnt !== 1'b0 || data_rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got rd=%b addr=%h dg=%b rdata=%h expected 0/0/0/0", mem_rd_req, mem_addr, data_gnt, data_rd_data);
        end
        #2 rstz = 1;
        data_rd_req = 0; instr_req = 1; instr_addr = 32'h40;
        #1; model_eval();
        checks++;
        if (instr_gnt !== 1'b1 || mem_addr !== 32'h40 || instr_data !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL reset_after: got ig=%b addr=%h data=%h expected 1/40/55aa55aa", instr_gnt, mem_addr, instr_data);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        bit ig, dg;
        for (int c = 0; c < 400; c++) begin
            if (!instr_req && $urandom_range(0, 2) != 0) begin
                instr_req = 1; instr_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(data_rd_req || data_wr_req) && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) != 0) data_rd_req = 1; else data_wr_req = 1;
                data_addr = $urandom & 32'hFFFF_FFFC; data_wr_data = $urandom;
            end
            if (m_hold == 1 && $urandom_range(0, 19) == 0) instr_req = 0;
            if (m_hold == 2 && $urandom_range(0, 19) == 0) begin data_rd_req = 0; data_wr_req = 0; end
            mem_gnt = ($urandom_range(0, 4) < 2);
            mem_rd_data = $urandom;
            #1; model_eval();
            checks++;
            if ({mem_addr, mem_wr_data, mem_rd_req, mem_wr_req, instr_gnt, data_gnt, instr_data, data_rd_data}
                !== {e_addr, e_wdata, e_rd, e_wr, e_ig, e_dg, e_rdata, e_rdata}) begin
                failures++;
                $display("FAIL random_c%0d: got addr=%h wd=%h rd=%b wr=%b ig=%b dg=%b expected addr=%h wd=%h rd=%b wr=%b ig=%b dg=%b",
                         c, mem_addr, mem_wr_data, mem_rd_req, mem_wr_req, instr_gnt, data_gnt,
                         e_addr, e_wdata, e_rd, e_wr, e_ig, e_dg);
            end
            checks++;
            if ((instr_gnt && data_gnt) || (mem_rd_req && mem_wr_req)) begin
                failures++;
                $display("FAIL random_excl_c%0d: got ig=%b dg=%b rd=%b wr=%b expected no overlap", c, instr_gnt, data_gnt, mem_rd_req, mem_wr_req);
            end
            ig = e_ig; dg = e_dg;
            tick();
            if (ig) instr_req = 0;
            if (dg) begin data_rd_req = 0; data_wr_req = 0; end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_cycle_instr();
`ifdef KRONOS_ARB_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_lock_instr();
        test_abort();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
